cplx_acc_result_capture: RTL and testbench
==========================================

// Module: cplx_acc_result_capture
// PURPOSE
//  Consumer end of the cplx_acc_dsp48 interface. Tracks the sload framing sent to the accumulator,
//  aligns it to the DSP pipeline latency, and captures each completed frame's final pr/pi sum.
//  Each result is scaled, saturated and queued with its frame length.
//  Results leave on a valid/ready stream toward the downstream packer.
// PARAMETERS
//  PW     40  accumulator output width (pr/pi), signed
//  LAT    4   cycles from sload_in/sample to first pr/pi reflecting that sample (DSP48 pipe)
//  SHIFT  0   arithmetic right shift applied to pr/pi before saturation, 0..PW-2
//  OW     24  output width of res_r/res_i, signed, OW <= PW-SHIFT
//  CW     16  frame-length counter width
//  DEPTH  8   result FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   asynchronous active-low reset
//  sload_in   in   1   same sload driven to the accumulator: sample this cycle starts a new frame
//  flush_in   in   1   sample this cycle is the last of the frame (closes frame without new sload)
//  pr, pi     in   PW  accumulator outputs, signed
//  out_valid  out  1   result available
//  out_ready  in   1   downstream accepts result
//  res_r      out  OW  saturated real part of frame sum
//  res_i      out  OW  saturated imag part of frame sum
//  res_len    out  CW  number of samples in frame
//  ovf        out  1   sticky: a result was dropped on full FIFO
//  ovf_clr    in   1   clears ovf
// BEHAVIOUR
//  - Reset (async, rst_n=0): delay pipes, armed, count, prev regs, FIFO pointers cleared;
//    out_valid=0, res_r=res_i=0, res_len=0, ovf=0. No capture until a marker follows deassertion.
//  - Alignment: m_s = sload_in delayed LAT cycles, m_f = flush_in delayed LAT cycles (shift regs).
//  - prev_r/prev_i register pr/pi every cycle.
//  - m_s=1: if armed, push {sat(prev_r), sat(prev_i), count}; then armed=1, count=1.
//  - m_f=1 and m_s=0: if armed, push {sat(pr), sat(pi), count+1 (saturated)}; armed=0, count=0.
//  - flush_in and sload_in in same cycle: flush ignored (sload closes previous frame, opens new).
//  - Otherwise while armed: count increments per cycle, saturates at 2^CW-1 (no wrap).
//  - sat(x): y = x >>> SHIFT (floor); clamp to [-2^(OW-1), 2^(OW-1)-1].
//  - Capture-to-out_valid latency: 1 cycle (FIFO registered write, first-word-fall-through read).
//  - Handshake: pop when out_valid&&out_ready. Outputs stable while out_valid&&!out_ready.
//    res_* hold last value when empty.
//  - Full: push dropped, ovf set; push and pop in same cycle while full is accepted (no ovf).
//    Empty: out_valid=0; no pop.
//  - ovf_clr and a new drop in same cycle: ovf stays 1.
//  - Pointer wrap: DEPTH power of 2, extra MSB for full/empty discrimination.
// STRUCTURE
//  - cplx_acc_pkg: typedef struct packed cplx_res_t {res_r, res_i, res_len}; sat function.
//  - Sub-module cplx_res_fifo #(DEPTH, type T=cplx_res_t): sync FIFO, FWFT, full/empty, async rst_n.
//  - Top: two LAT-deep delay regs, armed/count FSM (IDLE=!armed, ACC=armed), prev regs, sat, ovf.
// TESTING (LAT=4, SHIFT=0, OW=16, DEPTH=4; bench drives accumulator model or real cplx_acc_dsp48)
//  1 Reset held 3 cycles, random pr/pi -> out_valid=0, ovf=0, res_len=0; no push after release.
//  2 ar=1,br=2,ai=bi=0; sload on samples 0 and 3 -> after sample-3 marker one result (2*3=6, 0, len 3).
//  3 Frame sload@0, flush@1, then sload@5 -> push (4,0,2); sload@5 marker pushes nothing (disarmed).
//  4 pr=40000 / pr=-40000 at frame end -> res_r=32767 / -32768; pi=-5 -> res_i=-5.
//  5 out_ready=0, 5 single-frame results -> 4 queued, ovf=1; ready=1 -> drained in order, ovf holds
//    until ovf_clr.
//  6 rst_n low 2 cycles mid-frame with markers in flight -> FIFO empty, no push from stale markers.

Source files
------------

// File: rtl/cplx_acc_pkg.sv
// Shared types and helpers for the cplx_acc result-capture path.
package cplx_acc_pkg;

    localparam int unsigned RES_OW = 24;
    localparam int unsigned RES_CW = 16;

    typedef struct packed {
        logic signed [RES_OW-1:0] res_r;
        logic signed [RES_OW-1:0] res_i;
        logic [RES_CW-1:0]        res_len;
    } cplx_res_t;

    // Floor shift by sh, then clamp into a signed ow-bit range.
    function automatic logic signed [63:0] sat_fn(input logic signed [63:0] x,
                                                  input int unsigned       sh,
                                                  input int unsigned       ow);
        logic signed [63:0] y;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        y  = x >>> sh;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (y > hi)      sat_fn = hi;
        else if (y < lo) sat_fn = lo;
        else             sat_fn = y;
    endfunction

endpackage

// File: rtl/cplx_acc_result_capture_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head that holds its last value when empty.
module cplx_res_fifo
    import cplx_acc_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = cplx_res_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic valid_o,
    output logic full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    T           mem_q [DEPTH];
    T           data_q, data_d;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d, rd_inc;
    logic       valid_q, valid_d, full_q, full_d;
    logic       do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && valid_q;
        do_push = push_i && (!full_q || do_pop);
        rd_inc  = rd_q + (AW+1)'(1);
        wr_d    = wr_q + (AW+1)'(do_push);
        rd_d    = rd_q + (AW+1)'(do_pop);
        data_d  = data_q;
        // Head register tracks mem[rd]; a write into an empty queue bypasses memory.
        if (!valid_q) begin
            if (do_push) data_d = data_i;
        end else if (do_pop) begin
            if (rd_inc == wr_q) begin
                if (do_push) data_d = data_i;
            end else begin
                data_d = mem_q[rd_inc[AW-1:0]];
            end
        end
        valid_d = (wr_d != rd_d);
        full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            full_q  <= full_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign full_o  = full_q;

endmodule

// File: rtl/cplx_acc_result_capture.sv
// Aligns sload/flush framing to the DSP latency and queues each frame's saturated final sum.
module cplx_acc_result_capture
    import cplx_acc_pkg::*;
#(
    parameter int unsigned PW    = 40,
    parameter int unsigned LAT   = 4,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned OW    = 24,
    parameter int unsigned CW    = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sload_in,
    input  logic                 flush_in,
    input  logic signed [PW-1:0] pr,
    input  logic signed [PW-1:0] pi,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] res_r,
    output logic signed [OW-1:0] res_i,
    output logic [CW-1:0]        res_len,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    typedef struct packed {
        logic signed [OW-1:0] res_r;
        logic signed [OW-1:0] res_i;
        logic [CW-1:0]        res_len;
    } res_t;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [CW-1:0]        count_q, count_d, count_inc;
    logic [LAT-1:0]       sdly_q, sdly_d, fdly_q, fdly_d;
    logic signed [PW-1:0] prev_r_q, prev_i_q;
    logic                 ovf_q, ovf_d;
    logic                 m_s, m_f, push_c, fifo_full, fifo_valid;
    res_t                 push_data_c, fifo_data;

    assign m_s       = sdly_q[LAT-1];
    assign m_f       = fdly_q[LAT-1];
    assign count_inc = (count_q == {CW{1'b1}}) ? count_q : count_q + CW'(1);

    // Frame tracking: sload marker closes with the previous cycle's sum, flush with the current one.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        push_c      = 1'b0;
        push_data_c = '0;
        sdly_d      = LAT'({sdly_q, sload_in});
        fdly_d      = LAT'({fdly_q, flush_in});
        if (m_s) begin
            push_c              = (state_q == ACC);
            push_data_c.res_r   = OW'(sat_fn(64'(prev_r_q), SHIFT, OW));
            push_data_c.res_i   = OW'(sat_fn(64'(prev_i_q), SHIFT, OW));
            push_data_c.res_len = count_q;
            state_d             = ACC;
            count_d             = CW'(1);
        end else if (m_f) begin
            push_c              = (state_q == ACC);
            push_data_c.res_r   = OW'(sat_fn(64'(pr), SHIFT, OW));
            push_data_c.res_i   = OW'(sat_fn(64'(pi), SHIFT, OW));
            push_data_c.res_len = count_inc;
            state_d             = IDLE;
            count_d             = '0;
        end else if (state_q == ACC) begin
            count_d = count_inc;
        end
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (push_c && fifo_full && !(fifo_valid && out_ready)) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            sdly_q   <= '0;
            fdly_q   <= '0;
            prev_r_q <= '0;
            prev_i_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sdly_q   <= sdly_d;
            fdly_q   <= fdly_d;
            prev_r_q <= pr;
            prev_i_q <= pi;
            ovf_q    <= ovf_d;
        end
    end

    cplx_res_fifo #(
        .DEPTH (DEPTH),
        .T     (res_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .data_i  (push_data_c),
        .pop_i   (out_ready),
        .data_o  (fifo_data),
        .valid_o (fifo_valid),
        .full_o  (fifo_full)
    );

    assign out_valid = fifo_valid;
    assign res_r     = fifo_data.res_r;
    assign res_i     = fifo_data.res_i;
    assign res_len   = fifo_data.res_len;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cplx_acc_result_capture.sv
// Bench: accumulator emulation feeding the capture block, frame-level reference model, per-cycle compare.
module tb_cplx_acc_result_capture;

    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst_n, sload_in, flush_in, out_ready, ovf_clr;
    logic signed [39:0]  pr, pi;
    logic                out_valid, ovf;
    logic signed [15:0]  res_r, res_i;
    logic [15:0]         res_len;
    longint              prod_r, prod_i;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        longint r;
        longint i;
        longint len;
        longint due;
    } ent_t;

    ent_t   pend[$];
    ent_t   mq[$];
    ent_t   popped[$];
    ent_t   last;
    longint pipe_r[LAT];
    longint pipe_i[LAT];
    bit     m_ovf, open;
    longint sum_r, sum_i, flen, cyc;

    always #5 clk = ~clk;

    cplx_acc_result_capture #(
        .PW(40), .LAT(LAT), .SHIFT(0), .OW(16), .CW(16), .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sload_in  (sload_in),
        .flush_in  (flush_in),
        .pr        (pr),
        .pi        (pi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_r     (res_r),
        .res_i     (res_i),
        .res_len   (res_len),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic longint sat16(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_clear();
        pend.delete();
        mq.delete();
        last  = '{0, 0, 0, 0};
        m_ovf = 1'b0;
        open  = 1'b0;
        sum_r = 0;
        sum_i = 0;
        flen  = 0;
    endtask

    // Reference model, DSP emulation and per-cycle output compare.
    initial begin
        bit     s, f, rdy, clr, drop;
        longint ps_r, ps_i;
        ent_t   e;
        cyc = 0;
        pr  = '0;
        pi  = '0;
        for (int k = 0; k < LAT; k++) begin
            pipe_r[k] = 0;
            pipe_i[k] = 0;
        end
        model_clear();
        forever begin
            @(posedge clk);
            s = sload_in; f = flush_in; rdy = out_ready; clr = ovf_clr;
            ps_r = prod_r; ps_i = prod_i;
            cyc++;
            if (!rst_n) begin
                model_clear();
            end else begin
                drop = 1'b0;
                if (mq.size() > 0 && rdy) last = mq.pop_front();
                while (pend.size() > 0 && pend[0].due == cyc) begin
                    e = pend.pop_front();
                    if (mq.size() < DEPTH) mq.push_back(e);
                    else drop = 1'b1;
                end
                if (drop)     m_ovf = 1'b1;
                else if (clr) m_ovf = 1'b0;
                if (s) begin
                    if (open) pend.push_back('{sat16(sum_r), sat16(sum_i), flen, cyc + LAT});
                    open = 1'b1; sum_r = ps_r; sum_i = ps_i; flen = 1;
                end else if (open) begin
                    sum_r += ps_r; sum_i += ps_i;
                    if (flen < 65535) flen++;
                    if (f) begin
                        pend.push_back('{sat16(sum_r), sat16(sum_i), flen, cyc + LAT});
                        open = 1'b0;
                    end
                end
            end
            #1;
            for (int k = LAT - 1; k > 0; k--) begin
                pipe_r[k] = pipe_r[k-1];
                pipe_i[k] = pipe_i[k-1];
            end
            pipe_r[0] = s ? ps_r : pipe_r[0] + ps_r;
            pipe_i[0] = s ? ps_i : pipe_i[0] + ps_i;
            pr = 40'(pipe_r[LAT-1]);
            pi = 40'(pipe_i[LAT-1]);
            @(negedge clk);
            if (!rst_n) model_clear();
            e = (mq.size() != 0) ? mq[0] : last;
            chk("out_valid", longint'(out_valid), longint'(mq.size() != 0));
            chk("res_r", longint'(res_r), e.r);
            chk("res_i", longint'(res_i), e.i);
            chk("res_len", longint'(res_len), e.len);
            chk("ovf", longint'(ovf), longint'(m_ovf));
            if (rst_n && out_valid && out_ready)
                popped.push_back('{longint'(res_r), longint'(res_i), longint'(res_len), cyc});
        end
    end

    task automatic step(input bit s, input bit f, input longint r, input longint i);
        @(posedge clk);
        #1;
        sload_in = s; flush_in = f; prod_r = r; prod_i = i;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 0);
    endtask

    // Directed stimulus with hand-computed literal expectations.
    initial begin
        longint exp_r[11]   = '{6, 4, 4, 5, 32767, -32768, 7, 100, 200, 300, 400};
        longint exp_i[11]   = '{0, 0, 0, 0, -5, -5, 1, 1, 2, 3, 4};
        longint exp_len[11] = '{3, 2, 2, 2, 1, 1, 2, 1, 1, 1, 1};
        rst_n = 1'b0; sload_in = 1'b0; flush_in = 1'b0; prod_r = 0; prod_i = 0;
        out_ready = 1'b1; ovf_clr = 1'b0;

        // Reset held with random activity on the inputs
        repeat (3) begin
            @(posedge clk); #1;
            sload_in = 1'($urandom_range(0, 1));
            prod_r   = longint'($urandom_range(0, 1000));
            prod_i   = longint'($urandom_range(0, 1000));
        end
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_ovf", longint'(ovf), 0);
        chk("rst_len", longint'(res_len), 0);
        @(posedge clk); #1;
        rst_n = 1'b1; sload_in = 1'b0; prod_r = 0; prod_i = 0;
        idle(10);
        chk("post_rst_valid", longint'(out_valid), 0);

        // Constant product 2, sload at samples 0 and 3, flush at 4
        step(1, 0, 2, 0); step(0, 0, 2, 0); step(0, 0, 2, 0); step(1, 0, 2, 0); step(0, 1, 2, 0);
        idle(10);
        chk("t2_count", longint'(popped.size()), 2);

        // Flush closes frame; later sload while disarmed pushes nothing
        step(1, 0, 2, 0); step(0, 1, 2, 0);
        step(0, 0, 2, 0); step(0, 0, 2, 0); step(0, 0, 2, 0);
        step(1, 0, 2, 0); step(0, 1, 3, 0);
        idle(10);
        chk("t3_count", longint'(popped.size()), 4);

        // Saturation, and sload+flush on the same sample
        step(1, 0, 40000, -5); step(1, 0, -40000, -5); step(1, 1, 0, 0); step(0, 1, 7, 1);
        idle(10);
        chk("t4_count", longint'(popped.size()), 7);

        // Backpressure overflow and drain
        out_ready = 1'b0;
        step(1, 0, 100, 1); step(1, 0, 200, 2); step(1, 0, 300, 3);
        step(1, 0, 400, 4); step(1, 0, 500, 5); step(0, 1, 600, 6);
        idle(10);
        chk("t5_ovf_set", longint'(ovf), 1);
        chk("t5_valid", longint'(out_valid), 1);
        chk("t5_head_r", longint'(res_r), 100);
        chk("t5_head_len", longint'(res_len), 1);
        out_ready = 1'b1;
        idle(8);
        chk("t5_ovf_hold", longint'(ovf), 1);
        chk("t5_drained", longint'(out_valid), 0);
        @(posedge clk); #1; ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        chk("t5_ovf_clr", longint'(ovf), 0);
        chk("t5_count", longint'(popped.size()), 11);

        // Reset mid-frame with markers in flight
        step(1, 0, 2, 0); step(0, 0, 2, 0); step(1, 0, 2, 0);
        @(posedge clk); #1;
        rst_n = 1'b0; sload_in = 1'b0; flush_in = 1'b0; prod_r = 0; prod_i = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(12);
        chk("t6_valid", longint'(out_valid), 0);
        chk("t6_count", longint'(popped.size()), 11);

        if (popped.size() >= 11) begin
            for (int k = 0; k < 11; k++) begin
                chk($sformatf("lit_r%0d", k), popped[k].r, exp_r[k]);
                chk($sformatf("lit_i%0d", k), popped[k].i, exp_i[k]);
                chk($sformatf("lit_len%0d", k), popped[k].len, exp_len[k]);
            end
        end else begin
            chk("lit_size", longint'(popped.size()), 11);
        end

        // Mixed traffic with random ready and ovf_clr, checked by the model
        for (int k = 0; k < 80; k++) begin
            bit s, f;
            s = ($urandom_range(0, 3) == 0);
            f = !s && ($urandom_range(0, 4) == 0);
            step(s, f, longint'($urandom_range(0, 40000)) - 20000,
                 longint'($urandom_range(0, 40000)) - 20000);
            out_ready = 1'($urandom_range(0, 1));
            ovf_clr   = ($urandom_range(0, 7) == 0);
        end
        out_ready = 1'b1; ovf_clr = 1'b0;
        idle(20);
        chk("t7_drained", longint'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
